// File: rtl/spm_pkg.sv
// Shared types and default sizes for the scratchpad memory unit.
package spm_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } spm_state_t;

  typedef logic [ADDR_W_DEF-1:0] addr_t;
  typedef logic [DATA_W_DEF-1:0] data_t;

endpackage

// File: rtl/spm_init_fsm.sv
// Post-reset clear sequencer: walks every location once, then reports ready.
// Also latches any external write attempted before the sweep has finished.
module spm_init_fsm
  import spm_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              write_i,
  output logic              sweep_we_o,
  output logic [ADDR_W-1:0] sweep_addr_o,
  output logic              ready_o,
  output logic              init_wr_err_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  spm_state_t        state_q;
  logic [ADDR_W-1:0] init_ptr_q;
  logic              ready_q;
  logic              init_wr_err_q;

  // Sweep sequencer, ready flag and sticky early-write error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= INIT;
      init_ptr_q    <= {ADDR_W{1'b0}};
      ready_q       <= 1'b0;
      init_wr_err_q <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          // Pointer wraps to zero on the same edge that enters READY.
          init_ptr_q <= init_ptr_q + ADDR_W'(1);
          if (write_i) begin
            init_wr_err_q <= 1'b1;
          end
          if (init_ptr_q == LAST_ADDR) begin
            state_q <= READY;
            ready_q <= 1'b1;
          end
        end
        READY: begin
          state_q <= READY;
          ready_q <= 1'b1;
        end
        default: begin
          state_q    <= INIT;
          init_ptr_q <= {ADDR_W{1'b0}};
          ready_q    <= 1'b0;
        end
      endcase
    end
  end

  assign sweep_we_o    = (state_q == INIT);
  assign sweep_addr_o  = init_ptr_q;
  assign ready_o       = ready_q;
  assign init_wr_err_o = init_wr_err_q;

endmodule

// File: rtl/spm_mem.sv
// Single-port scratchpad with write-first registered read and a self-clear
// sweep after every reset; external accesses are honoured only once ready.
module spm_mem
  import spm_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter int unsigned       DATA_W   = DATA_W_DEF,
  parameter logic [DATA_W-1:0] INIT_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              write,
  output logic [DATA_W-1:0] data_out,
  output logic              ready,
  output logic              init_wr_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] data_out_d;
  logic [DATA_W-1:0] data_out_q;

  logic              sweep_we_s;
  logic [ADDR_W-1:0] sweep_addr_s;
  logic              ready_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic [DATA_W-1:0] mem_wdata_s;

  spm_init_fsm #(
    .ADDR_W (ADDR_W)
  ) u_init_fsm (
    .clk_i         (clk),
    .rst_ni        (rst),
    .write_i       (write),
    .sweep_we_o    (sweep_we_s),
    .sweep_addr_o  (sweep_addr_s),
    .ready_o       (ready_s),
    .init_wr_err_o (init_wr_err)
  );

  // Write-port mux: the sweep owns the array until it finishes.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = address;
    mem_wdata_s = data_in;
    if (sweep_we_s) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = sweep_addr_s;
      mem_wdata_s = INIT_VAL;
    end else begin
      mem_we_s    = write;
      mem_waddr_s = address;
      mem_wdata_s = data_in;
    end
  end

  // Storage array; contents are defined by the sweep, not by reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Read-data select: zero during the sweep, write-first once ready.
  always_comb begin
    data_out_d = {DATA_W{1'b0}};
    if (!ready_s) begin
      data_out_d = {DATA_W{1'b0}};
    end else if (write) begin
      data_out_d = data_in;
    end else begin
      data_out_d = mem_q[address];
    end
  end

  // Read-data register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out_q <= {DATA_W{1'b0}};
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;
  assign ready    = ready_s;

endmodule

// File: tb/tb_spm_mem.sv
// Directed bench for spm_mem: default-size instance plus a 16-deep
// instance with INIT_VAL=0xFF sharing clock and reset.
module tb_spm_mem;

  logic       clk;
  logic       rst;
  logic [7:0] address;
  logic [7:0] data_in;
  logic       write;
  logic [7:0] data_out;
  logic       ready;
  logic       init_wr_err;

  logic [3:0] s_address;
  logic [7:0] s_data_in;
  logic       s_write;
  logic [7:0] s_data_out;
  logic       s_ready;
  logic       s_init_wr_err;

  int n_cmp;
  int n_err;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] din;
    logic [7:0] exp_dout;
    string      name;
  } vec_t;

  vec_t vecs [16];

  spm_mem u_dut (
    .clk         (clk),
    .rst         (rst),
    .address     (address),
    .data_in     (data_in),
    .write       (write),
    .data_out    (data_out),
    .ready       (ready),
    .init_wr_err (init_wr_err)
  );

  spm_mem #(
    .ADDR_W   (4),
    .DATA_W   (8),
    .INIT_VAL (8'hFF)
  ) u_small (
    .clk         (clk),
    .rst         (rst),
    .address     (s_address),
    .data_in     (s_data_in),
    .write       (s_write),
    .data_out    (s_data_out),
    .ready       (s_ready),
    .init_wr_err (s_init_wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [7:0] a, input logic [7:0] d);
    write   = wr;
    address = a;
    data_in = d;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    drive(1'b0, 8'h00, 8'h00);
    s_write   = 1'b0;
    s_address = 4'h0;
    s_data_in = 8'h00;

    vecs[0]  = '{1'b0, 8'h00, 8'h00, 8'h00, "rd_00_clear"};
    vecs[1]  = '{1'b0, 8'h7F, 8'h00, 8'h00, "rd_7f_clear"};
    vecs[2]  = '{1'b0, 8'hFF, 8'h00, 8'h00, "rd_ff_clear"};
    vecs[3]  = '{1'b1, 8'h10, 8'hA5, 8'hA5, "wr_10_a5"};
    vecs[4]  = '{1'b1, 8'hFF, 8'h3C, 8'h3C, "wr_ff_3c"};
    vecs[5]  = '{1'b0, 8'h10, 8'h00, 8'hA5, "rd_10"};
    vecs[6]  = '{1'b0, 8'hFF, 8'h00, 8'h3C, "rd_ff"};
    vecs[7]  = '{1'b1, 8'h20, 8'h5A, 8'h5A, "wr_20_first"};
    vecs[8]  = '{1'b0, 8'h20, 8'h00, 8'h5A, "rd_20_next"};
    vecs[9]  = '{1'b0, 8'h05, 8'h00, 8'h00, "rd_05_dropped"};
    vecs[10] = '{1'b1, 8'h21, 8'h11, 8'h11, "alt_wr_21"};
    vecs[11] = '{1'b0, 8'h20, 8'h00, 8'h5A, "alt_rd_20"};
    vecs[12] = '{1'b1, 8'h22, 8'h33, 8'h33, "alt_wr_22"};
    vecs[13] = '{1'b0, 8'h21, 8'h00, 8'h11, "alt_rd_21"};
    vecs[14] = '{1'b0, 8'h22, 8'h00, 8'h33, "alt_rd_22"};
    vecs[15] = '{1'b0, 8'h11, 8'h00, 8'h00, "rd_11_neighbor"};

    #12;
    chk("rst_dout", {24'h0, data_out}, 32'h0);
    chk("rst_ready", {31'h0, ready}, 32'h0);
    chk("rst_err", {31'h0, init_wr_err}, 32'h0);
    chk("rst_small_ready", {31'h0, s_ready}, 32'h0);
    rst = 1'b1;

    // Initial sweep: early write at sweep cycle 10, small instance read-out.
    for (int n = 1; n <= 256; n++) begin
      if (n == 11) drive(1'b1, 8'h05, 8'hEE);
      else drive(1'b0, 8'h00, 8'h00);
      if (n >= 17 && n <= 32) s_address = 4'(n - 17);
      cycle();
      if (n == 10) chk("err_before_write", {31'h0, init_wr_err}, 32'h0);
      if (n == 11) chk("err_set", {31'h0, init_wr_err}, 32'h1);
      if (n == 128) chk("dout_during_init", {24'h0, data_out}, 32'h0);
      if (n == 255) chk("ready_at_255", {31'h0, ready}, 32'h0);
      if (n == 256) chk("ready_at_256", {31'h0, ready}, 32'h1);
      if (n == 15) chk("small_ready_at_15", {31'h0, s_ready}, 32'h0);
      if (n == 16) chk("small_ready_at_16", {31'h0, s_ready}, 32'h1);
      if (n >= 18 && n <= 33) chk("small_read_ff", {24'h0, s_data_out}, 32'hFF);
    end
    chk("err_sticky", {31'h0, init_wr_err}, 32'h1);

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].wr, vecs[i].addr, vecs[i].din);
      cycle();
      chk(vecs[i].name, {24'h0, data_out}, {24'h0, vecs[i].exp_dout});
    end
    chk("err_sticky_ready", {31'h0, init_wr_err}, 32'h1);

    // Asynchronous reset pulse between clock edges after writing 0x30.
    drive(1'b1, 8'h30, 8'h77);
    cycle();
    chk("wr_30_77", {24'h0, data_out}, 32'h77);
    drive(1'b0, 8'h30, 8'h00);
    chk("pre_rst_ready", {31'h0, ready}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_dout", {24'h0, data_out}, 32'h0);
    chk("async_ready", {31'h0, ready}, 32'h0);
    chk("async_err", {31'h0, init_wr_err}, 32'h0);
    #2;
    rst = 1'b1;

    for (int n = 1; n <= 256; n++) begin
      cycle();
      if (n == 255) chk("resweep_ready_255", {31'h0, ready}, 32'h0);
      if (n == 256) chk("resweep_ready_256", {31'h0, ready}, 32'h1);
    end
    drive(1'b0, 8'h30, 8'h00);
    cycle();
    chk("rd_30_cleared", {24'h0, data_out}, 32'h0);
    chk("err_after_reset", {31'h0, init_wr_err}, 32'h0);
    drive(1'b0, 8'h10, 8'h00);
    cycle();
    chk("rd_10_cleared", {24'h0, data_out}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
